// File: rtl/bnn_pkg.sv
// ============================================================================
// bnn_pkg : types and helpers shared by the BNN/MLP blocks
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package bnn_pkg;

  typedef enum logic [1:0] {
    LOAD_W = 2'd0,
    LOAD_T = 2'd1,
    COMMIT = 2'd2,
    DRAIN  = 2'd3
  } loader_state_e;

  // Number of bus words needed to carry the full weight matrix.
  function automatic int calc_w_words(input int num_neurons,
                                      input int input_size,
                                      input int bus_width);
    return (num_neurons * input_size + bus_width - 1) / bus_width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mlp_param_loader.sv
// ============================================================================
// mlp_param_loader : streams an MLP layer's weights and thresholds into
//                    shadow registers and commits complete frames atomically
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module mlp_param_loader
  import bnn_pkg::*;
#(
  parameter int INPUT_SIZE      = 64,
  parameter int NUM_NEURONS     = 10,
  parameter int THRESHOLD_WIDTH = $clog2(INPUT_SIZE + 1),
  parameter int BUS_WIDTH       = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  input  logic [BUS_WIDTH-1:0]                   s_data,
  input  logic                                   s_last,
  output logic [NUM_NEURONS*INPUT_SIZE-1:0]      weights,
  output logic [NUM_NEURONS*THRESHOLD_WIDTH-1:0] thresholds,
  output logic                                   params_valid,
  output logic                                   load_error
);

  localparam int c_w_words = calc_w_words(NUM_NEURONS, INPUT_SIZE, BUS_WIDTH);
  localparam int c_frame   = c_w_words + NUM_NEURONS;
  localparam int c_cnt_w   = (c_frame > 1) ? $clog2(c_frame) : 1;
  localparam int c_total_w = NUM_NEURONS * INPUT_SIZE;

  generate
    if (THRESHOLD_WIDTH > BUS_WIDTH) begin : g_width_check
      $error("mlp_param_loader: THRESHOLD_WIDTH must not exceed BUS_WIDTH");
    end
  endgenerate

  loader_state_e                          r_state, w_next_state;
  logic [c_cnt_w-1:0]                     r_cnt, w_cnt_next;
  logic                                   w_accept;
  logic                                   w_err;
  logic                                   r_commit_q;
  logic [c_total_w-1:0]                   r_shadow_w;
  logic [NUM_NEURONS*THRESHOLD_WIDTH-1:0] r_shadow_t;

  assign s_ready  = (r_state != COMMIT) && !rst;
  assign w_accept = s_valid && s_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LOAD_W;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_err        = 1'b0;
    case (r_state)
      LOAD_W: begin
        if (w_accept) begin
          if (s_last) begin
            w_err      = 1'b1;
            w_cnt_next = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
            if (r_cnt == c_cnt_w'(c_w_words - 1)) w_next_state = LOAD_T;
          end
        end
      end
      LOAD_T: begin
        if (w_accept) begin
          w_cnt_next = '0;
          if (r_cnt == c_cnt_w'(c_frame - 1)) begin
            if (s_last) begin
              w_next_state = COMMIT;
            end else begin
              w_err        = 1'b1;
              w_next_state = DRAIN;
            end
          end else if (s_last) begin
            w_err        = 1'b1;
            w_next_state = LOAD_W;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      COMMIT: w_next_state = LOAD_W;
      DRAIN: begin
        if (w_accept && s_last) w_next_state = LOAD_W;
      end
      default: begin
        w_next_state = LOAD_W;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Shadow capture; bits past the end of the matrix in the last weight word never match a bit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow_w <= '0;
      r_shadow_t <= '0;
    end else if (w_accept) begin
      if (r_state == LOAD_W) begin
        for (int b = 0; b < c_total_w; b++) begin
          if (r_cnt == c_cnt_w'(b / BUS_WIDTH)) r_shadow_w[b] <= s_data[b % BUS_WIDTH];
        end
      end else if (r_state == LOAD_T) begin
        for (int n = 0; n < NUM_NEURONS; n++) begin
          if (r_cnt == c_cnt_w'(c_w_words + n))
            r_shadow_t[n*THRESHOLD_WIDTH +: THRESHOLD_WIDTH] <= s_data[THRESHOLD_WIDTH-1:0];
        end
      end
    end
  end

  // The commit strobe is registered, so the active set moves on the edge that ends COMMIT + 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_commit_q   <= 1'b0;
      weights      <= '0;
      thresholds   <= '0;
      params_valid <= 1'b0;
      load_error   <= 1'b0;
    end else begin
      r_commit_q <= (r_state == COMMIT);
      load_error <= w_err;
      if (r_commit_q) begin
        weights      <= r_shadow_w;
        thresholds   <= r_shadow_t;
        params_valid <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mlp_param_loader.sv
// ============================================================================
// tb_mlp_param_loader : randomized and directed checks against a frame-level model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mlp_param_loader;

  localparam int IS    = 12;
  localparam int NN    = 2;
  localparam int BW    = 8;
  localparam int TW    = 4;
  localparam int WW    = 3;
  localparam int FRAME = WW + NN;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic [BW-1:0]    s_data;
  logic             s_last;
  logic [NN*IS-1:0] weights;
  logic [NN*TW-1:0] thresholds;
  logic             params_valid;
  logic             load_error;

  always #5 clk = ~clk;

  mlp_param_loader #(
    .INPUT_SIZE      (IS),
    .NUM_NEURONS     (NN),
    .THRESHOLD_WIDTH (TW),
    .BUS_WIDTH       (BW)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .weights      (weights),
    .thresholds   (thresholds),
    .params_valid (params_valid),
    .load_error   (load_error)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Frame-level model: collected words of the frame in progress plus the committed view.
  logic [BW-1:0]    m_words[$];
  bit               m_drain;
  int               m_cd;
  logic [NN*IS-1:0] m_w, m_pw;
  logic [NN*TW-1:0] m_t, m_pt;
  bit               m_pv, m_err;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic model_reset();
    m_words.delete();
    m_drain = 0; m_cd = 0; m_pv = 0; m_err = 0;
    m_w = '0; m_pw = '0; m_t = '0; m_pt = '0;
  endtask

  task automatic model_edge(input bit acc, input logic [BW-1:0] d, input bit l);
    logic [WW*BW-1:0] cat;
    m_err = 0;
    if (m_cd == 1) begin
      m_w = m_pw; m_t = m_pt; m_pv = 1;
    end
    if (m_cd > 0) m_cd--;
    if (acc) begin
      if (m_drain) begin
        if (l) m_drain = 0;
      end else begin
        m_words.push_back(d);
        if (m_words.size() == FRAME) begin
          if (l) begin
            cat = '0;
            for (int k = 0; k < WW; k++) cat[k*BW +: BW] = m_words[k];
            m_pw = cat[NN*IS-1:0];
            for (int n = 0; n < NN; n++) m_pt[n*TW +: TW] = m_words[WW+n][TW-1:0];
            m_cd = 2;
          end else begin
            m_err = 1; m_drain = 1;
          end
          m_words.delete();
        end else if (l) begin
          m_err = 1;
          m_words.delete();
        end
      end
    end
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model at the rising edge.
  task automatic step(input bit v, input logic [BW-1:0] d, input bit l, input bit r, output bit acc);
    bit exp_ready;
    s_valid = v; s_data = d; s_last = l; rst = r;
    if (r) model_reset();
    #1;
    exp_ready = !r && (m_cd != 2);
    check("s_ready", {31'b0, s_ready}, {31'b0, exp_ready});
    check("weights", 32'(weights), 32'(m_w));
    check("thresholds", 32'(thresholds), 32'(m_t));
    check("params_valid", {31'b0, params_valid}, {31'b0, m_pv});
    check("load_error", {31'b0, load_error}, {31'b0, m_err});
    acc = v && exp_ready;
    @(posedge clk);
    if (!r) model_edge(acc, d, l);
    @(negedge clk);
  endtask

  task automatic send(input logic [BW-1:0] d, input bit l);
    bit acc;
    int tries;
    acc = 0;
    tries = 0;
    while (!acc && tries < 4) begin
      step(1, d, l, 0, acc);
      tries++;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, BW'($urandom), 0, 0, acc);
  endtask

  task automatic send_frame(input logic [FRAME*BW-1:0] f, input int gap);
    for (int k = 0; k < FRAME; k++) begin
      send(f[k*BW +: BW], k == FRAME - 1);
      if (gap > 0 && k < FRAME - 1) idle(gap);
    end
  endtask

  initial begin
    bit acc;
    bit r, v, l;
    model_reset();
    rst = 1; s_valid = 0; s_data = '0; s_last = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 1, acc);

    // Reference frame, back to back
    send_frame({8'h0B, 8'h07, 8'hF1, 8'h3C, 8'hA5}, 0);
    idle(3);
    check("frame1_weights", 32'(weights), 32'h00F13CA5);
    check("frame1_thresh", 32'(thresholds), 32'h000000B7);

    // Same frame with gaps
    rst = 1; step(0, 8'h00, 0, 1, acc);
    send_frame({8'h0B, 8'h07, 8'hF1, 8'h3C, 8'hA5}, 3);
    idle(3);
    check("gap_weights", 32'(weights), 32'h00F13CA5);

    // Early s_last, then a good frame
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 1);
    idle(2);
    check("early_last_keep", 32'(weights), 32'h00F13CA5);
    send_frame({8'h5D, 8'h06, 8'h9E, 8'h81, 8'h42}, 1);
    idle(3);

    // Missing s_last on the final word, then drain
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0); send(8'h05, 0);
    send(8'hAA, 0); send(8'hBB, 1);
    idle(2);
    send_frame({8'h03, 8'h0C, 8'h77, 8'h66, 8'h55}, 0);
    idle(3);

    // Reset mid-frame
    send(8'hDE, 0); send(8'hAD, 0);
    step(0, 8'h00, 0, 1, acc);
    check("rst_weights", 32'(weights), 32'h0);
    send_frame({8'h09, 8'h0A, 8'h12, 8'h34, 8'h56}, 0);
    idle(3);
    check("post_rst_weights", 32'(weights), 32'h00123456);

    // Upper threshold bits ignored
    send_frame({8'h5A, 8'hFE, 8'h03, 8'h02, 8'h01}, 0);
    idle(3);
    check("thresh_trunc", {28'b0, thresholds[3:0]}, 32'hE);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 99) < 70);
      if (m_drain)                          l = ($urandom_range(0, 99) < 25);
      else if (m_words.size() == FRAME - 1) l = ($urandom_range(0, 99) < 85);
      else                                  l = ($urandom_range(0, 99) < 6);
      step(v, BW'($urandom), l, r, acc);
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
